// File: rtl/data_unpacker.sv
// rtl/data_unpacker.sv - wide-to-narrow LSB-first slice serializer with zero-bubble word reload
// Optional build macro: DATA_UNPACKER_STATS_EN adds stat_words/stat_slices transfer counters.
module data_unpacker #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 64,
    parameter int OP_WIDTH  = 16,
    localparam int NUM_LANES = IN_WIDTH / OUT_WIDTH,
    localparam int LANE_W    = $clog2(NUM_LANES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_read_req,
    output logic                 s_read_ready,
    input  logic [IN_WIDTH-1:0]  s_read_data,
    input  logic [LANE_W-1:0]    s_read_lanes,
    output logic                 m_read_req,
    input  logic                 m_read_ready,
    output logic [OUT_WIDTH-1:0] m_read_data,
    output logic                 m_read_last
`ifdef DATA_UNPACKER_STATS_EN
    ,
    output logic [31:0]          stat_words,
    output logic [31:0]          stat_slices
`endif
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_in_width
        $error("IN_WIDTH must be an integer multiple of OUT_WIDTH");
    end
    if ((OUT_WIDTH % OP_WIDTH) != 0) begin : g_bad_op_width
        $error("OUT_WIDTH must be an integer multiple of OP_WIDTH");
    end

    logic [0:0]          state_q, state_d;
    logic [IN_WIDTH-1:0] buf_q, buf_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [LANE_W-1:0]   limit_q, limit_d;
    logic [LANE_W-1:0]   lanes_eff;
    logic                s_xfer;
    logic                m_xfer;

    assign m_read_req   = (state_q == DRAIN);
    assign m_read_last  = (state_q == DRAIN) && (lane_q == limit_q);
    assign m_read_data  = buf_q[OUT_WIDTH-1:0];
    // Ready may rise in the same cycle the last slice leaves, giving back-to-back words.
    assign s_read_ready = (state_q == IDLE) || (m_read_last && m_read_ready);
    assign s_xfer       = s_read_req && s_read_ready;
    assign m_xfer       = m_read_req && m_read_ready;

    // Zero or out-of-range lane counts mean a full word.
    assign lanes_eff = ((s_read_lanes == '0) || (s_read_lanes > LANE_W'(NUM_LANES)))
                       ? LANE_W'(NUM_LANES) : s_read_lanes;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        lane_d  = lane_q;
        limit_d = limit_q;
        if (s_xfer) begin
            buf_d   = s_read_data;
            lane_d  = '0;
            limit_d = lanes_eff - LANE_W'(1);
            state_d = DRAIN;
        end else if (m_xfer) begin
            if (m_read_last) begin
                state_d = IDLE;
            end else begin
                buf_d  = buf_q >> OUT_WIDTH;
                lane_d = lane_q + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            lane_q  <= '0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            lane_q  <= lane_d;
            limit_q <= limit_d;
        end
    end

`ifdef DATA_UNPACKER_STATS_EN
    logic [31:0] stat_words_q, stat_words_d;
    logic [31:0] stat_slices_q, stat_slices_d;

    always_comb begin
        stat_words_d  = stat_words_q + (s_xfer ? 32'd1 : 32'd0);
        stat_slices_d = stat_slices_q + (m_xfer ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_words_q  <= '0;
            stat_slices_q <= '0;
        end else begin
            stat_words_q  <= stat_words_d;
            stat_slices_q <= stat_slices_d;
        end
    end

    assign stat_words  = stat_words_q;
    assign stat_slices = stat_slices_q;
`endif

endmodule

// File: tb/tb_data_unpacker.sv
// tb/tb_data_unpacker.sv - directed and randomized checks of data_unpacker against a slice-queue model
module tb_data_unpacker;

    localparam int IW = 128;
    localparam int OW = 64;
    localparam int NL = IW / OW;
    localparam int LW = $clog2(NL + 1);

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
    } slice_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_read_req;
    logic          s_read_ready;
    logic [IW-1:0] s_read_data;
    logic [LW-1:0] s_read_lanes;
    logic          m_read_req;
    logic          m_read_ready;
    logic [OW-1:0] m_read_data;
    logic          m_read_last;
`ifdef DATA_UNPACKER_STATS_EN
    logic [31:0]   stat_words;
    logic [31:0]   stat_slices;
`endif

    data_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .OP_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_read_req   (s_read_req),
        .s_read_ready (s_read_ready),
        .s_read_data  (s_read_data),
        .s_read_lanes (s_read_lanes),
        .m_read_req   (m_read_req),
        .m_read_ready (m_read_ready),
        .m_read_data  (m_read_data),
        .m_read_last  (m_read_last)
`ifdef DATA_UNPACKER_STATS_EN
        ,
        .stat_words   (stat_words),
        .stat_slices  (stat_slices)
`endif
    );

    always #5 clk = ~clk;

    slice_t exp_q[$];
    int     n_compared = 0;
    int     n_failed   = 0;
    int     n_words    = 0;
    int     n_slices   = 0;

    task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [IW-1:0] d, input logic [LW-1:0] ln);
        int     n;
        slice_t s;
        n = (ln == 0 || int'(ln) > NL) ? NL : int'(ln);
        for (int i = 0; i < n; i++) begin
            s.data = OW'(d >> (OW * i));
            s.last = (i == n - 1);
            exp_q.push_back(s);
        end
    endtask

    // One clock: drive at the falling edge, check against the model, then account for transfers.
    task automatic cycle(input logic sreq, input logic [IW-1:0] d, input logic [LW-1:0] ln,
                         input logic mrdy, output logic sx, output logic mx);
        @(negedge clk);
        s_read_req   = sreq;
        s_read_data  = d;
        s_read_lanes = ln;
        m_read_ready = mrdy;
        #1;
        chk("s_ready", IW'(s_read_ready), IW'((exp_q.size() == 0) || (exp_q.size() == 1 && mrdy)));
        chk("m_req", IW'(m_read_req), IW'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("m_data", IW'(m_read_data), IW'(exp_q[0].data));
            chk("m_last", IW'(m_read_last), IW'(exp_q[0].last));
        end
        sx = sreq && s_read_ready;
        mx = m_read_req && mrdy;
        if (mx && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            n_slices++;
        end
        if (sx) begin
            push_word(d, ln);
            n_words++;
        end
    endtask

    function automatic logic [IW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic          sx, mx;
        logic [IW-1:0] w [3];
        logic [IW-1:0] pend_d;
        logic [LW-1:0] pend_l;
        logic          pend;
        int            idx, mcount, guard;

        reset = 1'b1;
        s_read_req = 1'b0; s_read_data = '0; s_read_lanes = '0; m_read_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_m_req", IW'(m_read_req), '0);
        chk("rst_m_data", IW'(m_read_data), '0);
        chk("rst_m_last", IW'(m_read_last), '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_s_ready", IW'(s_read_ready), IW'(1'b1));

        // Full word, lanes=0 means all lanes
        cycle(1'b1, {{16{4'h1}}, {16{4'h2}}}, '0, 1'b1, sx, mx);
        cycle(1'b0, '0, '0, 1'b1, sx, mx);
        chk("t1_slice0", IW'(m_read_data), IW'({16{4'h2}}));
        chk("t1_last0", IW'(m_read_last), '0);
        cycle(1'b0, '0, '0, 1'b1, sx, mx);
        chk("t1_slice1", IW'(m_read_data), IW'({16{4'h1}}));
        chk("t1_last1", IW'(m_read_last), IW'(1'b1));
        cycle(1'b0, '0, '0, 1'b1, sx, mx);

        // Three words back-to-back: six slices over six consecutive cycles
        for (int i = 0; i < 3; i++) w[i] = rnd_word();
        idx = 0; mcount = 0;
        for (int c = 0; c < 7; c++) begin
            cycle(idx < 3, (idx < 3) ? w[idx] : '0, LW'(0), 1'b1, sx, mx);
            if (sx) idx++;
            if (mx) mcount++;
        end
        chk("t2_words", IW'(idx), IW'(3));
        chk("t2_slices", IW'(mcount), IW'(6));

        // Stall for five cycles, then drain
        w[0] = rnd_word();
        cycle(1'b1, w[0], '0, 1'b0, sx, mx);
        for (int c = 0; c < 5; c++) cycle(1'b0, '0, '0, 1'b0, sx, mx);
        chk("t3_hold", IW'(m_read_data), IW'(w[0][OW-1:0]));
        for (int c = 0; c < 3; c++) cycle(1'b0, '0, '0, 1'b1, sx, mx);

        // lanes=1: upper half is never emitted
        cycle(1'b1, {64'hDEAD_BEEF_DEAD_BEEF, 64'h5}, LW'(1), 1'b1, sx, mx);
        cycle(1'b0, '0, '0, 1'b1, sx, mx);
        chk("t4_data", IW'(m_read_data), IW'(64'h5));
        chk("t4_last", IW'(m_read_last), IW'(1'b1));
        cycle(1'b0, '0, '0, 1'b1, sx, mx);
        chk("t4_idle", IW'(m_read_req), '0);

        // Out-of-range lane count clamps to a full word
        cycle(1'b1, rnd_word(), LW'(3), 1'b1, sx, mx);
        for (int c = 0; c < 3; c++) cycle(1'b0, '0, '0, 1'b1, sx, mx);

        // Asynchronous reset after the first slice
        cycle(1'b1, rnd_word(), '0, 1'b1, sx, mx);
        cycle(1'b0, '0, '0, 1'b1, sx, mx);
        @(negedge clk);
        m_read_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5_m_req", IW'(m_read_req), '0);
        chk("t5_m_data", IW'(m_read_data), '0);
        chk("t5_m_last", IW'(m_read_last), '0);
        exp_q.delete();
        n_words = 0; n_slices = 0;
`ifdef DATA_UNPACKER_STATS_EN
        chk("t5_stat_words", IW'(stat_words), '0);
        chk("t5_stat_slices", IW'(stat_slices), '0);
`endif
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, rnd_word(), '0, 1'b1, sx, mx);
        for (int c = 0; c < 3; c++) cycle(1'b0, '0, '0, 1'b1, sx, mx);

        // Randomized traffic with backpressure
        pend = 1'b0; pend_d = '0; pend_l = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                pend   = 1'b1;
                pend_d = rnd_word();
                pend_l = LW'($urandom_range(0, (1 << LW) - 1));
            end
            cycle(pend, pend_d, pend_l, $urandom_range(0, 3) != 0, sx, mx);
            if (sx) pend = 1'b0;
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            cycle(1'b0, '0, '0, 1'b1, sx, mx);
            guard++;
        end
        chk("drain_empty", IW'(exp_q.size()), '0);
`ifdef DATA_UNPACKER_STATS_EN
        chk("stat_words", IW'(stat_words), IW'(n_words));
        chk("stat_slices", IW'(stat_slices), IW'(n_slices));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
